// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory bus master (req/ack), RISC-V load
// extension and store lane steering, branch resolution, and MEM/WB register.
module mem_stage #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_MEM,
    input  logic        MemtoReg_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic        Branch_MEM,
    input  logic [31:0] PC_MEM,
    input  logic [2:0]  FUNCT3_MEM,
    input  logic [31:0] ALU_OUT_MEM,
    input  logic        ZERO_MEM,
    input  logic [31:0] REG_DATA2_MEM,
    input  logic [4:0]  RD_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic        PCSrc,
    output logic [31:0] PC_BRANCH_OUT,
    output logic        RegWrite_WB,
    output logic        MemtoReg_WB,
    output logic [31:0] READ_DATA_WB,
    output logic [31:0] ALU_OUT_WB,
    output logic [4:0]  RD_WB,
    output logic        misalign_exc,
    output logic        bus_err
);

    // Wait-counter value seen in the last BUSY cycle before giving up.
    localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] wait_cnt;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic        access, aligned, start, misalign_now, timeout, load_done;
    logic [3:0]  store_be;
    logic [31:0] store_wdata, load_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Access legality and store byte-lane steering from the EX/MEM inputs.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        access      = MemRead_MEM | MemWrite_MEM;
        aligned     = 1'b0;
        store_be    = 4'b1111;
        store_wdata = REG_DATA2_MEM;
        case (FUNCT3_MEM[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~ALU_OUT_MEM[0];
            2'b10:   aligned = (ALU_OUT_MEM[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        if (MemWrite_MEM) begin
            case (FUNCT3_MEM[1:0])
                2'b00: begin
                    store_be    = 4'b0001 << ALU_OUT_MEM[1:0];
                    store_wdata = {4{REG_DATA2_MEM[7:0]}};
                end
                2'b01: begin
                    store_be    = ALU_OUT_MEM[1] ? 4'b1100 : 4'b0011;
                    store_wdata = {2{REG_DATA2_MEM[15:0]}};
                end
                default: begin
                    store_be    = 4'b1111;
                    store_wdata = REG_DATA2_MEM;
                end
            endcase
        end
    end

    // Next-state, stall and event decode for the bus FSM.
    always_comb begin
        state_nxt    = state;
        stall_mem    = 1'b0;
        start        = 1'b0;
        misalign_now = 1'b0;
        timeout      = 1'b0;
        load_done    = 1'b0;
        case (state)
            IDLE: begin
                if (access && aligned) begin
                    start     = 1'b1;
                    stall_mem = 1'b1;
                    state_nxt = BUSY;
                end else if (access) begin
                    misalign_now = 1'b1;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    load_done = ~dmem_we;
                    state_nxt = IDLE;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall_mem = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Bus request register: latch the access on entry, hold it while BUSY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
            dmem_be    <= 4'h0;
            funct3_q   <= 3'h0;
            lane_q     <= 2'h0;
            wait_cnt   <= 16'h0;
        end else if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite_MEM;
            dmem_addr  <= {ALU_OUT_MEM[31:2], 2'b00};
            dmem_wdata <= store_wdata;
            dmem_be    <= store_be;
            funct3_q   <= FUNCT3_MEM;
            lane_q     <= ALU_OUT_MEM[1:0];
            wait_cnt   <= 16'h0;
        end else if (state == BUSY) begin
            if (dmem_ack || timeout) dmem_req <= 1'b0;
            wait_cnt <= wait_cnt + 16'h1;
        end
    end

    // Load lane selection and sign/zero extension of the returned word.
    always_comb begin
        load_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
        load_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {24'h0, load_byte};
            3'b101:  load_data = {16'h0, load_half};
            default: load_data = dmem_rdata;
        endcase
    end

    // MEM/WB register with bubble insertion on stall or exception.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite_WB  <= 1'b0;
            MemtoReg_WB  <= 1'b0;
            READ_DATA_WB <= 32'h0;
            ALU_OUT_WB   <= 32'h0;
            RD_WB        <= 5'h0;
        end else if (stall_mem || misalign_now || timeout) begin
            RegWrite_WB  <= 1'b0;
            MemtoReg_WB  <= 1'b0;
            READ_DATA_WB <= 32'h0;
            ALU_OUT_WB   <= 32'h0;
            RD_WB        <= 5'h0;
        end else begin
            RegWrite_WB  <= RegWrite_MEM;
            MemtoReg_WB  <= MemtoReg_MEM;
            READ_DATA_WB <= load_done ? load_data : 32'h0;
            ALU_OUT_WB   <= ALU_OUT_MEM;
            RD_WB        <= RD_MEM;
        end
    end

    // One-cycle exception pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_exc <= misalign_now;
            bus_err      <= timeout;
        end
    end

    // Branch resolution; the compare result arrives in ALU_OUT_MEM[0].
    always_comb begin
        PCSrc = 1'b0;
        if (Branch_MEM) begin
            case (FUNCT3_MEM)
                3'b000:         PCSrc = ZERO_MEM;
                3'b001:         PCSrc = ~ZERO_MEM;
                3'b100, 3'b110: PCSrc = ALU_OUT_MEM[0];
                3'b101, 3'b111: PCSrc = ~ALU_OUT_MEM[0];
                default:        PCSrc = 1'b0;
            endcase
        end
    end

    assign PC_BRANCH_OUT = PC_MEM;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of expected MEM/WB results,
// immediate-assertion checks, ACK_TIMEOUT reduced to 4.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, MemWrite_MEM, Branch_MEM;
    logic [31:0] PC_MEM;
    logic [2:0]  FUNCT3_MEM;
    logic [31:0] ALU_OUT_MEM;
    logic        ZERO_MEM;
    logic [31:0] REG_DATA2_MEM;
    logic [4:0]  RD_MEM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_mem, PCSrc;
    logic [31:0] PC_BRANCH_OUT;
    logic        RegWrite_WB, MemtoReg_WB;
    logic [31:0] READ_DATA_WB, ALU_OUT_WB;
    logic [4:0]  RD_WB;
    logic        misalign_exc, bus_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        rw;
        logic        mtr;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
    } wb_t;

    wb_t sb_q[$];

    mem_stage #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .Branch_MEM(Branch_MEM), .PC_MEM(PC_MEM), .FUNCT3_MEM(FUNCT3_MEM),
        .ALU_OUT_MEM(ALU_OUT_MEM), .ZERO_MEM(ZERO_MEM),
        .REG_DATA2_MEM(REG_DATA2_MEM), .RD_MEM(RD_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall_mem(stall_mem), .PCSrc(PCSrc),
        .PC_BRANCH_OUT(PC_BRANCH_OUT), .RegWrite_WB(RegWrite_WB),
        .MemtoReg_WB(MemtoReg_WB), .READ_DATA_WB(READ_DATA_WB),
        .ALU_OUT_WB(ALU_OUT_WB), .RD_WB(RD_WB),
        .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        RegWrite_MEM = 0; MemtoReg_MEM = 0; MemRead_MEM = 0; MemWrite_MEM = 0;
        Branch_MEM = 0; PC_MEM = 0; FUNCT3_MEM = 0; ALU_OUT_MEM = 0;
        ZERO_MEM = 0; REG_DATA2_MEM = 0; RD_MEM = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic drive_mem(input logic rd_en, input logic wr_en, input logic rw,
                             input logic mtr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic [4:0] rd);
        idle();
        MemRead_MEM = rd_en; MemWrite_MEM = wr_en; RegWrite_MEM = rw;
        MemtoReg_MEM = mtr; FUNCT3_MEM = f3; ALU_OUT_MEM = addr;
        REG_DATA2_MEM = data; RD_MEM = rd;
    endtask

    task automatic expect_wb(input logic rw, input logic mtr, input logic [4:0] rd,
                             input logic [31:0] alu, input logic [31:0] rdata);
        wb_t e;
        e.rw = rw; e.mtr = mtr; e.rd = rd; e.alu = alu; e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    // Called at posedge+1 with the access already driven; ack arrives in
    // BUSY cycle n_ack. Returns at posedge+1 after the ack edge.
    task automatic run_access(input string tag, input int n_ack, input logic [31:0] rdata,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic exp_we);
        wb_t e;
        @(negedge clk);
        check({tag, " idle stall"}, 32'(stall_mem), 32'd1);
        check({tag, " idle req"}, 32'(dmem_req), 32'd0);
        for (int i = 1; i <= n_ack; i++) begin
            @(posedge clk); #1;
            if (i == n_ack) begin
                dmem_ack = 1'b1;
                dmem_rdata = rdata;
            end
            @(negedge clk);
            check({tag, " req"}, 32'(dmem_req), 32'd1);
            check({tag, " addr"}, dmem_addr, exp_addr);
            check({tag, " be"}, 32'(dmem_be), 32'(exp_be));
            check({tag, " we"}, 32'(dmem_we), 32'(exp_we));
            if (exp_we) check({tag, " wdata"}, dmem_wdata, exp_wdata);
            check({tag, " busy stall"}, 32'(stall_mem), (i == n_ack) ? 32'd0 : 32'd1);
        end
        @(posedge clk); #1;
        idle();
        check({tag, " req drop"}, 32'(dmem_req), 32'd0);
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, " RegWrite_WB"}, 32'(RegWrite_WB), 32'(e.rw));
            check({tag, " MemtoReg_WB"}, 32'(MemtoReg_WB), 32'(e.mtr));
            check({tag, " RD_WB"}, 32'(RD_WB), 32'(e.rd));
            check({tag, " ALU_OUT_WB"}, ALU_OUT_WB, e.alu);
            check({tag, " READ_DATA_WB"}, READ_DATA_WB, e.rdata);
        end
    endtask

    // Misaligned access: no request, no stall, bubble and one-cycle pulse.
    task automatic run_misalign(input string tag, input logic [2:0] f3, input logic [31:0] addr);
        drive_mem(1, 0, 1, 1, f3, addr, 32'h0, 5'd9);
        @(negedge clk);
        check({tag, " stall"}, 32'(stall_mem), 32'd0);
        check({tag, " req"}, 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        check({tag, " exc"}, 32'(misalign_exc), 32'd1);
        check({tag, " req after"}, 32'(dmem_req), 32'd0);
        check({tag, " RegWrite_WB"}, 32'(RegWrite_WB), 32'd0);
        check({tag, " RD_WB"}, 32'(RD_WB), 32'd0);
        idle();
        @(posedge clk); #1;
        check({tag, " exc clear"}, 32'(misalign_exc), 32'd0);
    endtask

    // Branch cases: {funct3, zero, alu_bit0, expected PCSrc}
    logic [5:0] br_tab [8] = '{
        {3'b001, 1'b0, 1'b0, 1'b1},
        {3'b001, 1'b1, 1'b0, 1'b0},
        {3'b000, 1'b1, 1'b0, 1'b1},
        {3'b000, 1'b0, 1'b0, 1'b0},
        {3'b100, 1'b0, 1'b1, 1'b1},
        {3'b101, 1'b0, 1'b1, 1'b0},
        {3'b111, 1'b0, 1'b0, 1'b1},
        {3'b010, 1'b1, 1'b1, 1'b0}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst req", 32'(dmem_req), 32'd0);
        check("rst be", 32'(dmem_be), 32'd0);
        check("rst RegWrite_WB", 32'(RegWrite_WB), 32'd0);
        check("rst stall", 32'(stall_mem), 32'd0);
        check("rst exc", 32'({misalign_exc, bus_err}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // sw, ack in third BUSY cycle
        drive_mem(0, 1, 0, 0, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0);
        expect_wb(0, 0, 5'd0, 32'h100, 32'h0);
        run_access("sw", 3, 32'h0, 32'h100, 4'b1111, 32'hDEADBEEF, 1'b1);

        // lb / lbu on byte lane 3
        drive_mem(1, 0, 1, 1, 3'b000, 32'h203, 32'h0, 5'd5);
        expect_wb(1, 1, 5'd5, 32'h203, 32'hFFFFFF80);
        run_access("lb", 1, 32'h80FF00AA, 32'h200, 4'b1111, 32'h0, 1'b0);
        drive_mem(1, 0, 1, 1, 3'b100, 32'h203, 32'h0, 5'd5);
        expect_wb(1, 1, 5'd5, 32'h203, 32'h00000080);
        run_access("lbu", 1, 32'h80FF00AA, 32'h200, 4'b1111, 32'h0, 1'b0);

        // lh / lhu upper half, lw, funct3=110 as full word
        drive_mem(1, 0, 1, 1, 3'b001, 32'h202, 32'h0, 5'd6);
        expect_wb(1, 1, 5'd6, 32'h202, 32'hFFFF80FF);
        run_access("lh", 2, 32'h80FF00AA, 32'h200, 4'b1111, 32'h0, 1'b0);
        drive_mem(1, 0, 1, 1, 3'b101, 32'h202, 32'h0, 5'd6);
        expect_wb(1, 1, 5'd6, 32'h202, 32'h000080FF);
        run_access("lhu", 1, 32'h80FF00AA, 32'h200, 4'b1111, 32'h0, 1'b0);
        drive_mem(1, 0, 1, 1, 3'b010, 32'h204, 32'h0, 5'd7);
        expect_wb(1, 1, 5'd7, 32'h204, 32'h12345678);
        run_access("lw", 1, 32'h12345678, 32'h204, 4'b1111, 32'h0, 1'b0);
        drive_mem(1, 0, 1, 1, 3'b110, 32'h208, 32'h0, 5'd8);
        expect_wb(1, 1, 5'd8, 32'h208, 32'h8765ABCD);
        run_access("f3_110", 1, 32'h8765ABCD, 32'h208, 4'b1111, 32'h0, 1'b0);

        // sub-word stores
        drive_mem(0, 1, 0, 0, 3'b001, 32'h102, 32'h1234ABCD, 5'd0);
        expect_wb(0, 0, 5'd0, 32'h102, 32'h0);
        run_access("sh_hi", 1, 32'h0, 32'h100, 4'b1100, 32'hABCDABCD, 1'b1);
        drive_mem(0, 1, 0, 0, 3'b001, 32'h100, 32'h1234ABCD, 5'd0);
        expect_wb(0, 0, 5'd0, 32'h100, 32'h0);
        run_access("sh_lo", 1, 32'h0, 32'h100, 4'b0011, 32'hABCDABCD, 1'b1);
        drive_mem(0, 1, 0, 0, 3'b000, 32'h101, 32'h000000EF, 5'd0);
        expect_wb(0, 0, 5'd0, 32'h101, 32'h0);
        run_access("sb", 1, 32'h0, 32'h100, 4'b0010, 32'hEFEFEFEF, 1'b1);
        // read+write together is a write
        drive_mem(1, 1, 0, 0, 3'b010, 32'h10C, 32'h55AA55AA, 5'd0);
        expect_wb(0, 0, 5'd0, 32'h10C, 32'h0);
        run_access("rw_both", 1, 32'hFFFFFFFF, 32'h10C, 4'b1111, 32'h55AA55AA, 1'b1);

        // misaligned accesses
        run_misalign("mis_lw", 3'b010, 32'h102);
        run_misalign("mis_lh", 3'b001, 32'h101);
        run_misalign("mis_f3_11", 3'b011, 32'h100);

        // timeout after 4 BUSY cycles without ack
        drive_mem(1, 0, 1, 1, 3'b010, 32'h300, 32'h0, 5'd7);
        @(negedge clk);
        check("to idle stall", 32'(stall_mem), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("to req", 32'(dmem_req), 32'd1);
            check("to stall", 32'(stall_mem), (i == 4) ? 32'd0 : 32'd1);
        end
        @(posedge clk); #1;
        check("to req drop", 32'(dmem_req), 32'd0);
        check("to bus_err", 32'(bus_err), 32'd1);
        check("to RegWrite_WB", 32'(RegWrite_WB), 32'd0);
        check("to RD_WB", 32'(RD_WB), 32'd0);
        idle();
        @(posedge clk); #1;
        check("to bus_err clear", 32'(bus_err), 32'd0);
        drive_mem(1, 0, 1, 1, 3'b010, 32'h400, 32'h0, 5'd3);
        expect_wb(1, 1, 5'd3, 32'h400, 32'hCAFEF00D);
        run_access("after_to", 1, 32'hCAFEF00D, 32'h400, 4'b1111, 32'h0, 1'b0);

        // branches
        for (int i = 0; i < 8; i++) begin
            logic [5:0] row;
            row = br_tab[i];
            idle();
            Branch_MEM = 1'b1; PC_MEM = 32'h40 + 32'(i * 4);
            FUNCT3_MEM = row[5:3]; ZERO_MEM = row[2]; ALU_OUT_MEM = {31'h0, row[1]};
            #1;
            check($sformatf("br%0d PCSrc", i), 32'(PCSrc), 32'(row[0]));
            check($sformatf("br%0d target", i), PC_BRANCH_OUT, 32'h40 + 32'(i * 4));
            check($sformatf("br%0d stall", i), 32'(stall_mem), 32'd0);
        end
        idle();
        FUNCT3_MEM = 3'b000; ZERO_MEM = 1'b1; #1;
        check("no_branch PCSrc", 32'(PCSrc), 32'd0);
        @(posedge clk); #1;

        // asynchronous reset while BUSY
        drive_mem(0, 1, 0, 0, 3'b010, 32'h500, 32'h0BADF00D, 5'd0);
        @(posedge clk); #1;
        check("rb req", 32'(dmem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        idle();
        #1;
        check("rb req", 32'(dmem_req), 32'd0);
        check("rb addr", dmem_addr, 32'h0);
        check("rb wdata", dmem_wdata, 32'h0);
        check("rb be/we", 32'({dmem_be, dmem_we}), 32'd0);
        check("rb stall", 32'(stall_mem), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        drive_mem(0, 1, 0, 0, 3'b010, 32'h600, 32'h11223344, 5'd0);
        expect_wb(0, 0, 5'd0, 32'h600, 32'h0);
        run_access("post_rst_sw", 2, 32'h0, 32'h600, 4'b1111, 32'h11223344, 1'b1);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage fed directly by the EX/MEM pipeline register.
- Drives a variable-latency data-memory bus (req/ack), performs RISC-V load sign/zero-extension and store byte-lane steering, resolves branches, and holds the MEM/WB register.
- Stalls upstream stages with stall_mem while a memory access is outstanding; stall_mem drives the EX/MEM write enable low.

Parameters:
ACK_TIMEOUT, 255, max cycles in BUSY without dmem_ack before abort with bus_err (1..65535)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, MemWrite_MEM, Branch_MEM  in  1 each  control from EX/MEM
PC_MEM  in  32  branch target
FUNCT3_MEM  in  3  access size/sign or branch type
ALU_OUT_MEM  in  32  address / ALU result / compare result (bit0)
ZERO_MEM  in  1  ALU zero flag
REG_DATA2_MEM  in  32  store data
RD_MEM  in  5  destination register
dmem_req  out  1  bus request, registered
dmem_we  out  1  1 = write
dmem_addr  out  32  {ALU_OUT_MEM[31:2],2'b00}, held while dmem_req=1
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ack  in  1  single-cycle completion
dmem_rdata  in  32  valid when dmem_ack=1
stall_mem  out  1  freeze PC/IF/ID/EX/EX-MEM
PCSrc  out  1  branch taken
PC_BRANCH_OUT  out  32  = PC_MEM
RegWrite_WB, MemtoReg_WB  out  1 each  MEM/WB control
READ_DATA_WB  out  32  extended load data
ALU_OUT_WB  out  32  ALU result
RD_WB  out  5  destination
misalign_exc  out  1  one-cycle pulse
bus_err  out  1  one-cycle pulse

Behaviour:
- Reset: state IDLE; all registered outputs 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, MEM/WB fields, misalign_exc, bus_err). Asserting reset mid-access drops dmem_req immediately; the in-flight access is discarded.
- access = MemRead_MEM | MemWrite_MEM. If both are 1, the access is a write.
- Alignment: 
  - byte accesses are always aligned.
  - halfword (funct3[1:0]=01) requires addr[0]=0.
  - word (10) requires addr[1:0]=0.
  - funct3[1:0]=11 is treated as misaligned.
- FSM:
  - IDLE: on aligned access, latch addr/we/be/wdata, set dmem_req=1, go BUSY. On misaligned access, pulse misalign_exc next cycle, no request, no stall, MEM/WB gets a bubble.
  - BUSY: hold all dmem_* stable. On dmem_ack, dmem_req←0, go IDLE. If the wait counter reaches ACK_TIMEOUT, dmem_req←0, pulse bus_err, MEM/WB bubble, go IDLE.
- stall_mem (combinational) = (IDLE & aligned access) | (BUSY & ~dmem_ack & ~timeout). Latency for an ack in the first BUSY cycle: 2 cycles with stall high for 1.
- Stores:
  - sb: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - sh: be=addr[1]?1100:0011, wdata={2{data[15:0]}}.
  - sw: be=1111, wdata=data.
  - Reads use be=1111.
- Loads (on ack, lane from addr[1:0]): funct3 000 lb sign-extend, 001 lh sign-extend, 010 lw, 100 lbu zero-extend, 101 lhu zero-extend. Any other funct3 is loaded as a full word.
- MEM/WB register:
  - When stall_mem=0, latch RegWrite/MemtoReg/ALU_OUT/RD from the inputs and READ_DATA from the extended rdata (else 0).
  - When stall_mem=1 or on exception, load a bubble: RegWrite_WB=0, MemtoReg_WB=0, RD_WB=0.
- Branch (combinational, Branch_MEM=1), PCSrc=1 when:
  - 000 beq and ZERO
  - 001 bne and ~ZERO
  - 100/110 blt/bltu and ALU_OUT_MEM[0]=1
  - 101/111 bge/bgeu and ALU_OUT_MEM[0]=0
  - 010/011 never
- A Branch with access set is illegal; the branch is still resolved.

Test Plan:
- sw, ALU_OUT=0x100, data=0xDEADBEEF, ack 3 cycles later -> dmem_req=1, be=1111, addr=0x100, we=1 for 3 cycles; stall_mem high until the ack cycle; RegWrite_WB=0.
- lb addr=0x203, ack with rdata=0x80FF_00AA, RegWrite=1, RD=5 -> READ_DATA_WB=0xFFFFFF80, RD_WB=5 one cycle after ack; same with lbu -> 0x00000080.
- sh addr=0x102 data=0x1234ABCD -> be=1100, wdata=0xABCDABCD; lw addr=0x102 -> misalign_exc pulse, dmem_req stays 0, stall_mem=0.
- ACK_TIMEOUT=4, lw with no ack -> dmem_req drops after 4 BUSY cycles, bus_err pulses, next instruction proceeds.
- Branch_MEM=1, funct3=001, ZERO=0, PC_MEM=0x40 -> PCSrc=1, PC_BRANCH_OUT=0x40; ZERO=1 -> PCSrc=0.
- Reset asserted in BUSY, asynchronously -> dmem_req=0 immediately, all outputs 0, state IDLE; after release, a new sw issues normally.
